// File: rtl/fifo_in_bin_scheduler.sv
// ---------------------------------------------------------------------------
// fifo_in_bin_scheduler
//
// Read-side sequencer between the input buffer FIFO and the FFT core. After
// each accepted start it pulls nPointsPerBin samples per range bin from the
// FIFO, zero-pads every bin to NFFT points and frames it as one FFT input
// frame. It repeats this for nBins bins and then pulses done.
//
// Handshakes:
//   - FIFO: fifo_rd_en is a read request that is taken whenever it is high.
//     The read data arrives with fifo_valid exactly one cycle later.
//   - FFT: fft_rfd is sampled only between frames. Once a frame has started,
//     it is streamed to the end with fft_valid qualifying each sample.
//     Gaps in fft_valid are legal.
//
// Ports:
//   clk            system clock (the FIFO runs on the same clock)
//   rst            asynchronous active-low reset
//   start          one-cycle trigger that begins a shot
//   nPointsPerBin  real samples per range bin (1..NFFT)
//   nBins          range bins per shot (>= 1)
//   fifo_empty     FIFO empty flag
//   fifo_dout      FIFO read data
//   fifo_valid     FIFO read-data valid
//   fft_rfd        FFT core ready for a new frame
//   fifo_rd_en     FIFO read enable
//   fft_data       frame sample (0 when fft_valid is low)
//   fft_valid      fft_data valid
//   fft_sof        first sample of a frame
//   fft_eof        last (NFFT-1) sample of a frame
//   bin_index      bin currently being framed
//   busy           high from an accepted start until done
//   done           one-cycle pulse after the last bin's eof
//   cfg_err        one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module fifo_in_bin_scheduler #(
    parameter int BIT_WIDTH = 14,
    parameter int NFFT      = 1024,
    parameter int CNT_W     = 11,
    parameter int NBIN_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          nPointsPerBin,
    input  logic [NBIN_W-1:0]    nBins,
    input  logic                 fifo_empty,
    input  logic [BIT_WIDTH-1:0] fifo_dout,
    input  logic                 fifo_valid,
    input  logic                 fft_rfd,
    output logic                 fifo_rd_en,
    output logic [BIT_WIDTH-1:0] fft_data,
    output logic                 fft_valid,
    output logic                 fft_sof,
    output logic                 fft_eof,
    output logic [NBIN_W-1:0]    bin_index,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RFD,
        S_READ,
        S_PAD,
        S_FRAME_END,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] NFFT_C = CNT_W'(NFFT);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NFFT - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     npts_q, npts_d;
    logic [NBIN_W-1:0]    nbins_q, nbins_d;
    logic [NBIN_W-1:0]    bin_q, bin_d;
    logic [CNT_W-1:0]     issued_q, issued_d;
    logic [CNT_W-1:0]     recv_q, recv_d;
    logic [CNT_W-1:0]     out_q, out_d;
    logic [BIT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 sof_q, sof_d;
    logic                 eof_q, eof_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;

    logic cfg_bad;
    logic rd_en;
    logic take;
    logic emit;

    // nPointsPerBin is checked at full 16-bit width before it is truncated
    // into the CNT_W-bit latch.
    assign cfg_bad = (nPointsPerBin == 16'd0) || (nPointsPerBin > 16'(NFFT)) ||
                     (nBins == '0);

    // Read requests come only from registered state, so the FIFO sees a
    // glitch-free enable that depends on fifo_empty alone.
    assign rd_en = (state_q == S_READ) && !fifo_empty && (issued_q < npts_q);

    // FIFO data is accepted only while reading. Stray fifo_valid in other
    // states produces no output.
    assign take = (state_q == S_READ) && fifo_valid;
    assign emit = take || (state_q == S_PAD);

    always_comb begin
        state_d   = state_q;
        npts_d    = npts_q;
        nbins_d   = nbins_q;
        bin_d     = bin_q;
        issued_d  = issued_q;
        recv_d    = recv_q;
        out_d     = out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cfg_err_d = start && (state_q == S_IDLE) && cfg_bad;

        // Output sample register: real data from the FIFO or zero padding.
        // out_q is the position of the sample within the frame.
        valid_d = emit;
        data_d  = take ? fifo_dout : '0;
        sof_d   = emit && (out_q == '0);
        eof_d   = emit && (out_q == LAST_C);
        if (emit) begin
            out_d = out_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start && !cfg_bad) begin
                    state_d = S_WAIT_RFD;
                    npts_d  = nPointsPerBin[CNT_W-1:0];
                    nbins_d = nBins;
                    bin_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT_RFD: begin
                if (fft_rfd) begin
                    state_d  = S_READ;
                    issued_d = '0;
                    recv_d   = '0;
                    out_d    = '0;
                end
            end
            S_READ: begin
                if (rd_en) begin
                    issued_d = issued_q + CNT_W'(1);
                end
                if (take) begin
                    recv_d = recv_q + CNT_W'(1);
                    // The last real sample leaves the register the next
                    // cycle. Padding therefore starts right behind it.
                    if (recv_q + CNT_W'(1) == npts_q) begin
                        state_d = (npts_q < NFFT_C) ? S_PAD : S_FRAME_END;
                    end
                end
            end
            S_PAD: begin
                if (out_q == LAST_C) begin
                    state_d = S_FRAME_END;
                end
            end
            S_FRAME_END: begin
                if (bin_q == nbins_q - NBIN_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    bin_d   = bin_q + NBIN_W'(1);
                    state_d = S_WAIT_RFD;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            npts_q    <= '0;
            nbins_q   <= '0;
            bin_q     <= '0;
            issued_q  <= '0;
            recv_q    <= '0;
            out_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            npts_q    <= npts_d;
            nbins_q   <= nbins_d;
            bin_q     <= bin_d;
            issued_q  <= issued_d;
            recv_q    <= recv_d;
            out_q     <= out_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign fft_data   = data_q;
    assign fft_valid  = valid_q;
    assign fft_sof    = sof_q;
    assign fft_eof    = eof_q;
    assign bin_index  = bin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_fifo_in_bin_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fifo_in_bin_scheduler
//
// Bench for fifo_in_bin_scheduler with a behavioural single-clock FIFO. Each
// shot preloads the FIFO and pushes the expected frame samples to exp_q as
// {bin, sof, eof, data}. A negedge monitor pops exp_q and compares it with
// every fft_valid sample. Scenario tasks check the counters, timing and
// control outputs.
// ---------------------------------------------------------------------------
module tb_fifo_in_bin_scheduler;
    localparam int BW     = 14;
    localparam int NFFT   = 1024;
    localparam int CNT_W  = 11;
    localparam int NBIN_W = 5;
    localparam int EW     = NBIN_W + 2 + BW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       npts = '0;
    logic [NBIN_W-1:0] nbins = '0;
    logic              fifo_empty = 1'b1;
    logic [BW-1:0]     fifo_dout = '0;
    logic              fifo_valid = 1'b0;
    logic              fft_rfd = 1'b1;
    logic              fifo_rd_en;
    logic [BW-1:0]     fft_data;
    logic              fft_valid;
    logic              fft_sof;
    logic              fft_eof;
    logic [NBIN_W-1:0] bin_index;
    logic              busy;
    logic              done;
    logic              cfg_err;

    fifo_in_bin_scheduler #(
        .BIT_WIDTH(BW), .NFFT(NFFT), .CNT_W(CNT_W), .NBIN_W(NBIN_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .nPointsPerBin(npts), .nBins(nbins),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
        .fft_rfd(fft_rfd), .fifo_rd_en(fifo_rd_en), .fft_data(fft_data),
        .fft_valid(fft_valid), .fft_sof(fft_sof), .fft_eof(fft_eof),
        .bin_index(bin_index), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [EW-1:0] exp_q[$];
    logic [BW-1:0] fifo_q[$];
    logic [EW-1:0] exp_e;

    int cyc = 0, rd_cnt = 0, pop_cnt = 0, done_cnt = 0, cfg_cnt = 0;
    int valid_cnt = 0, gap_cnt = 0, eof_cyc = 0, done_cyc = 0;
    int empty_hold = 0, gap_at = -1, gap_done = -1;
    bit pend = 1'b0, in_frame = 1'b0;
    logic [BW-1:0] pend_data = '0;

    // FIFO read port: take the request at the clock edge.
    always @(posedge clk) begin
        cyc++;
        pend = 1'b0;
        if (rst && fifo_rd_en) begin
            rd_cnt++;
            pend = 1'b1;
            pend_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
            pop_cnt++;
        end
    end

    // FIFO outputs are driven on the negedge. The output scoreboard also runs here.
    always @(negedge clk) begin
        fifo_valid = pend;
        fifo_dout  = pend ? pend_data : '0;
        if (gap_at >= 0 && pop_cnt == gap_at && gap_done != gap_at) begin
            empty_hold = 10;
            gap_done = gap_at;
        end
        fifo_empty = (fifo_q.size() == 0) || (empty_hold > 0);
        if (empty_hold > 0) empty_hold--;

        if (!rst) in_frame = 1'b0;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (cfg_err) cfg_cnt++;
        if (fft_valid) begin
            valid_cnt++;
            if (fft_sof) in_frame = 1'b1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_sample: got bin=%0d sof=%0b eof=%0b data=%0h, expected no sample",
                         bin_index, fft_sof, fft_eof, fft_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({bin_index, fft_sof, fft_eof, fft_data} !== exp_e) begin
                    n_err++;
                    $display("FAIL frame_sample: got bin=%0d sof=%0b eof=%0b data=%0h, expected bin=%0d sof=%0b eof=%0b data=%0h",
                             bin_index, fft_sof, fft_eof, fft_data,
                             exp_e[EW-1 -: NBIN_W], exp_e[BW+1], exp_e[BW], exp_e[BW-1:0]);
                end
            end
            if (fft_eof) begin in_frame = 1'b0; eof_cyc = cyc; end
        end else if (in_frame) begin
            gap_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load_shot(input int np, input int nb);
        logic [BW-1:0] d;
        logic [NBIN_W-1:0] bb;
        for (int b = 0; b < nb; b++) begin
            bb = NBIN_W'(b);
            for (int i = 0; i < NFFT; i++) begin
                if (i < np) begin
                    d = BW'($urandom_range(1, (1 << BW) - 1));
                    fifo_q.push_back(d);
                end else begin
                    d = '0;
                end
                exp_q.push_back({bb, i == 0, i == NFFT - 1, d});
            end
        end
    endtask

    task automatic pulse_start(input int np, input int nb);
        step();
        start = 1'b1;
        npts  = 16'(np);
        nbins = NBIN_W'(nb);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 5000) begin step(); n++; end
        n_vec++;
        if (done_cnt == d0) begin
            n_err++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, n);
        end
    endtask

    task automatic check_shot_end(input string name, input int rd0, input int rd_exp, input int d0);
        int gap_d;
        repeat (3) step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_frames: got %0d samples missing, expected 0", name, exp_q.size());
        end
        n_vec++;
        if (rd_cnt - rd0 != rd_exp) begin
            n_err++;
            $display("FAIL %s_rd_en: got %0d reads, expected %0d", name, rd_cnt - rd0, rd_exp);
        end
        n_vec++;
        if (done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL %s_done_count: got %0d, expected 1", name, done_cnt - d0);
        end
        n_vec++;
        if (done_cyc - eof_cyc != 2) begin
            n_err++;
            $display("FAIL %s_done_latency: got %0d cycles after eof, expected 2", name, done_cyc - eof_cyc);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_busy_end: got %0b, expected 0", name, busy);
        end
        gap_d = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        n_vec++;
        if ({fifo_rd_en, fft_data, fft_valid, fft_sof, fft_eof, bin_index, busy, done, cfg_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rd=%0b data=%0h v=%0b sof=%0b eof=%0b bin=%0d busy=%0b done=%0b cfg=%0b, expected all 0",
                     fifo_rd_en, fft_data, fft_valid, fft_sof, fft_eof, bin_index, busy, done, cfg_err);
        end
        rst = 1'b1;
        repeat (3) step();
        n_vec++;
        if ({fifo_rd_en, fft_valid, busy, done, cfg_err} !== '0) begin
            n_err++;
            $display("FAIL idle_outputs: got rd=%0b v=%0b busy=%0b done=%0b cfg=%0b, expected all 0",
                     fifo_rd_en, fft_valid, busy, done, cfg_err);
        end
    endtask

    task automatic test_basic();
        int rd0 = rd_cnt, d0 = done_cnt, g0 = gap_cnt;
        load_shot(250, 2);
        pulse_start(250, 2);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy: got %0b, expected 1", busy);
        end
        wait_done("basic");
        check_shot_end("basic", rd0, 500, d0);
        n_vec++;
        if (gap_cnt - g0 != 0) begin
            n_err++;
            $display("FAIL basic_gaps: got %0d gap cycles, expected 0", gap_cnt - g0);
        end
    endtask

    task automatic test_fifo_gap();
        int rd0 = rd_cnt, d0 = done_cnt, g0 = gap_cnt;
        gap_at = pop_cnt + 100;
        load_shot(250, 1);
        pulse_start(250, 1);
        wait_done("gap");
        check_shot_end("gap", rd0, 250, d0);
        n_vec++;
        if (gap_cnt - g0 != 10) begin
            n_err++;
            $display("FAIL gap_length: got %0d gap cycles, expected 10", gap_cnt - g0);
        end
    endtask

    task automatic test_full_frame();
        int rd0 = rd_cnt, d0 = done_cnt;
        load_shot(1024, 1);
        pulse_start(1024, 1);
        wait_done("full");
        check_shot_end("full", rd0, 1024, d0);
    endtask

    task automatic test_cfg_err();
        int rd0 = rd_cnt, c0 = cfg_cnt;
        int np_t[3] = '{0, 1025, 100};
        int nb_t[3] = '{1, 1, 0};
        for (int k = 0; k < 3; k++) begin
            pulse_start(np_t[k], nb_t[k]);
            n_vec++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL cfg_err_pulse_%0d: got cfg_err=%0b busy=%0b, expected 1 0", k, cfg_err, busy);
            end
            step();
            n_vec++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL cfg_err_clear_%0d: got cfg_err=%0b busy=%0b, expected 0 0", k, cfg_err, busy);
            end
        end
        n_vec++;
        if (rd_cnt != rd0 || cfg_cnt - c0 != 3) begin
            n_err++;
            $display("FAIL cfg_err_totals: got reads=%0d pulses=%0d, expected 0 3", rd_cnt - rd0, cfg_cnt - c0);
        end
    endtask

    task automatic test_rfd_hold();
        int rd0 = rd_cnt, d0 = done_cnt, c0 = cfg_cnt;
        fft_rfd = 1'b0;
        load_shot(100, 1);
        pulse_start(100, 1);
        repeat (50) step();
        n_vec++;
        if (rd_cnt != rd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rfd_hold: got reads=%0d busy=%0b, expected 0 1", rd_cnt - rd0, busy);
        end
        pulse_start(0, 3);
        n_vec++;
        if (cfg_err !== 1'b0 || busy !== 1'b1 || cfg_cnt != c0) begin
            n_err++;
            $display("FAIL busy_start_ignored: got cfg_err=%0b busy=%0b, expected 0 1", cfg_err, busy);
        end
        fft_rfd = 1'b1;
        wait_done("rfd");
        check_shot_end("rfd", rd0, 100, d0);
    endtask

    task automatic test_reset_mid_frame();
        int v0 = valid_cnt, n = 0, rd0, d0;
        load_shot(700, 1);
        pulse_start(700, 1);
        while (valid_cnt - v0 < 600 && n < 3000) begin step(); n++; end
        n_vec++;
        if (valid_cnt - v0 < 600) begin
            n_err++;
            $display("FAIL midrst_timeout: got %0d samples, expected 600", valid_cnt - v0);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({fifo_rd_en, fft_data, fft_valid, fft_sof, fft_eof, bin_index, busy, done, cfg_err} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: got rd=%0b data=%0h v=%0b sof=%0b eof=%0b bin=%0d busy=%0b, expected all 0",
                     fifo_rd_en, fft_data, fft_valid, fft_sof, fft_eof, bin_index, busy);
        end
        exp_q.delete();
        fifo_q.delete();
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();
        rd0 = rd_cnt;
        d0 = done_cnt;
        load_shot(100, 1);
        pulse_start(100, 1);
        wait_done("postrst");
        check_shot_end("postrst", rd0, 100, d0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_gap();
        test_full_frame();
        test_cfg_err();
        test_rfd_hold();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_in_bin_scheduler.md
Name: fifo_in_bin_scheduler

Overview:
Read-side sequencer for the 28-in/14-out input buffer FIFO.
- After each trigger, pulls nPointsPerBin samples per range bin from the FIFO.
- Appends zeros up to NFFT points and frames each bin as one FFT input frame (sof/eof/valid).
- Steps through nBins bins, then signals done.
- Sits between the input buffer FIFO and the FFT core; replaces free-running rd_en generation.

Parameters:
BIT_WIDTH, 14, sample width of FIFO dout and FFT data.
NFFT, 1024, zero-padded FFT frame length; power of two.
CNT_W, 11, sample counter width; must hold NFFT (clog2(NFFT)+1).
NBIN_W, 5, width of bin count/index (max 16 bins used).

Ports:
clk  in  1  system clock; FIFO read and write clocks are this clock.
rst  in  1  asynchronous, active-low reset (asserted at 0).
start  in  1  one-cycle trigger; begins a shot.
nPointsPerBin  in  16  real samples per range bin.
nBins  in  NBIN_W  number of range bins per shot.
fifo_empty  in  1  FIFO empty flag.
fifo_dout  in  BIT_WIDTH  FIFO read data.
fifo_valid  in  1  FIFO read-data valid; 1 cycle after an accepted rd_en.
fft_rfd  in  1  FFT core ready for a new frame.
fifo_rd_en  out  1  FIFO read enable.
fft_data  out  BIT_WIDTH  frame sample; 0 when fft_valid=0.
fft_valid  out  1  fft_data valid.
fft_sof  out  1  first sample of frame (with fft_valid).
fft_eof  out  1  sample NFFT-1 of frame (with fft_valid).
bin_index  out  NBIN_W  bin currently being framed.
busy  out  1  high from accepted start to done.
done  out  1  one-cycle pulse after the last bin's eof.
cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters 0.
- Parameter latch: nPointsPerBin and nBins are latched on an accepted start and held for the shot.
- start handling:
  - start in IDLE with nPointsPerBin=0, nPointsPerBin>NFFT, or nBins=0 -> cfg_err pulse next cycle; stay IDLE.
  - start in any other state is ignored.
- States:
  - IDLE: accepted start -> WAIT_RFD; busy=1; bin_index=0.
  - WAIT_RFD: fft_rfd=1 -> READ; issue/recv/out counters cleared.
  - READ:
    - fifo_rd_en = !fifo_empty && (issued < npts), combinational from registered counters.
    - Each rd_en increments issued; each fifo_valid increments recv.
    - Registered output: on fifo_valid, fft_data<=fifo_dout, fft_valid<=1.
    - Latency rd_en -> fft_valid = 2 cycles.
    - FIFO empty creates gaps in fft_valid; gaps are legal.
    - recv==npts: if npts<NFFT -> PAD, else -> FRAME_END.
  - PAD: emits (NFFT-npts) zero samples, one per cycle, fft_valid=1 continuously; no rd_en. Last zero -> FRAME_END.
  - FRAME_END (1 cycle, no output):
    - bin_index==nBins-1 -> DONE.
    - Otherwise bin_index++ -> WAIT_RFD.
  - DONE: done=1 and busy<=0 for one cycle -> IDLE.
- Framing rules:
  - out counter counts fft_valid cycles 0..NFFT-1.
  - fft_sof when out==0; fft_eof when out==NFFT-1.
  - Exactly NFFT valid samples per frame.
  - Zeros never precede the last real sample.
- fifo_valid outside READ: ignored, no output.
- fft_rfd is sampled only in WAIT_RFD; deassertion mid-frame has no effect.
- Reset mid-frame: immediate return to IDLE; any partial frame is abandoned. The FIFO is reset by the same rst.

Test Plan:
- npts=250, nBins=2, FIFO never empty, rfd=1 -> per frame 250 FIFO samples then 774 zeros; sof on first valid, eof on 1024th; bin_index 0 then 1; done once; 500 rd_en total.
- npts=250, FIFO empty for 10 cycles after sample 100 -> fft_valid gap of 10; frame still exactly 1024 valid samples; data order preserved.
- npts=1024, nBins=1 -> no PAD; eof on 1024th FIFO sample; done 2 cycles later.
- start with npts=0, then npts=1025, then nBins=0 -> cfg_err pulse each time; busy stays 0; no rd_en.
- fft_rfd held 0 for 50 cycles after start -> no rd_en until rfd=1; second start during busy -> ignored.
- rst=0 at sample 600 of bin 0 -> all outputs 0 immediately; a new start after release gives a clean frame from bin 0.
